// File: rtl/conv_1x1_sched_if.sv
// ---------------------------------------------------------------------------
// conv_1x1_sched_if
// Read-port bundle between the 1x1 conv sequencer and the weight/pixel
// memories.
//   mem_grant    memory -> seq   shared memory port available this cycle
//   wgt_rd_en    seq -> memory   weight read strobe
//   wgt_rd_addr  seq -> memory   weight read address
//   wgt_rd_data  memory -> seq   weight word, valid 1 cycle after wgt_rd_en
//   pxl_rd_en    seq -> memory   pixel read strobe
//   pxl_rd_addr  seq -> memory   pixel read address
//   pxl_rd_data  memory -> seq   pixel word, valid 1 cycle after pxl_rd_en
// Modports: master = sequencer side, slave = memory side.
// ---------------------------------------------------------------------------
interface conv_1x1_sched_if #(
   parameter int DATA_WIDTH = 32,
   parameter int W_ADDR_W   = 20,
   parameter int P_ADDR_W   = 20
);
   logic                  mem_grant;
   logic                  wgt_rd_en;
   logic [W_ADDR_W-1:0]   wgt_rd_addr;
   logic [DATA_WIDTH-1:0] wgt_rd_data;
   logic                  pxl_rd_en;
   logic [P_ADDR_W-1:0]   pxl_rd_addr;
   logic [DATA_WIDTH-1:0] pxl_rd_data;

   modport master (
      input  mem_grant,
      output wgt_rd_en,
      output wgt_rd_addr,
      input  wgt_rd_data,
      output pxl_rd_en,
      output pxl_rd_addr,
      input  pxl_rd_data
   );

   modport slave (
      output mem_grant,
      input  wgt_rd_en,
      input  wgt_rd_addr,
      output wgt_rd_data,
      input  pxl_rd_en,
      input  pxl_rd_addr,
      output pxl_rd_data
   );
endinterface

// File: rtl/conv_1x1_sched.sv
// ---------------------------------------------------------------------------
// conv_1x1_sched
// Sequencer for the 1x1 convolution chain. One layer per accepted start:
// for every output channel it loads CHANNEL_NUM_IN weights into the conv
// core, streams the whole input feature map from pixel memory, then waits
// for IMAGE_SIZE results from the channel adder.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             one-cycle layer start (ignored unless idle)
//   stride2_cfg       stride-2 mode, latched on accepted start
//   mem_bus           weight/pixel read ports (conv_1x1_sched_if.master)
//   valid_weight_in   weight forward strobe to conv core
//   weight_in         weight word to conv core
//   valid_in          pixel forward strobe to loop-data block
//   pxl_in            pixel word to loop-data block
//   stride2           latched stride-2 mode
//   res_valid         result strobe from channel adder
//   oc_idx            current output channel
//   busy              high from accepted start until done
//   done              one-cycle pulse at layer end
// ---------------------------------------------------------------------------
module conv_1x1_sched #(
   parameter int DATA_WIDTH      = 32,
   parameter int CHANNEL_NUM_IN  = 2048,
   parameter int CHANNEL_NUM_OUT = 256,
   parameter int IMAGE_SIZE      = 256,
   parameter int W_ADDR_W        = 20,
   parameter int P_ADDR_W        = 20
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stride2_cfg,
   conv_1x1_sched_if.master      mem_bus,
   output logic                  valid_weight_in,
   output logic [DATA_WIDTH-1:0] weight_in,
   output logic                  valid_in,
   output logic [DATA_WIDTH-1:0] pxl_in,
   output logic                  stride2,
   input  logic                  res_valid,
   output logic [15:0]           oc_idx,
   output logic                  busy,
   output logic                  done
);

   localparam int IC_W = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
   localparam int RC_W = $clog2(IMAGE_SIZE + 1);

   localparam logic [IC_W-1:0]     IC_LAST  = IC_W'(CHANNEL_NUM_IN - 1);
   localparam logic [P_ADDR_W-1:0] P_LAST   = P_ADDR_W'(IMAGE_SIZE * CHANNEL_NUM_IN - 1);
   localparam logic [RC_W-1:0]     RC_LAST  = RC_W'(IMAGE_SIZE - 1);
   localparam logic [15:0]         OC_LAST  = 16'(CHANNEL_NUM_OUT - 1);
   localparam logic [W_ADDR_W-1:0] W_STRIDE = W_ADDR_W'(CHANNEL_NUM_IN);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t                state_r, state_nxt_s;
   logic [IC_W-1:0]       ic_r;
   logic [P_ADDR_W-1:0]   p_r;
   logic [RC_W-1:0]       res_cnt_r;
   logic [W_ADDR_W-1:0]   w_base_r;      // oc_idx*CHANNEL_NUM_IN, kept incrementally
   logic [15:0]           oc_r;
   logic                  busy_r;
   logic                  stride2_r;
   logic                  vw_r;
   logic                  vp_r;
   logic [DATA_WIDTH-1:0] w_hold_r;
   logic [DATA_WIDTH-1:0] p_hold_r;

   logic                  wgt_rd_en_s;
   logic                  pxl_rd_en_s;
   logic                  start_acc_s;
   logic                  w_issue_s;
   logic                  p_issue_s;
   logic                  res_hit_s;
   logic                  res_last_s;
   logic                  ch_next_s;
   logic                  layer_end_s;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode and per-cycle control strobes
   always_comb begin
      state_nxt_s = state_r;
      wgt_rd_en_s = 1'b0;
      pxl_rd_en_s = 1'b0;
      start_acc_s = 1'b0;
      w_issue_s   = 1'b0;
      p_issue_s   = 1'b0;
      res_hit_s   = 1'b0;
      res_last_s  = 1'b0;
      ch_next_s   = 1'b0;
      layer_end_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               start_acc_s = 1'b1;
               state_nxt_s = LOAD_W;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOAD_W: begin
            wgt_rd_en_s = mem_bus.mem_grant;
            w_issue_s   = mem_bus.mem_grant;
            if (mem_bus.mem_grant && (ic_r == IC_LAST)) begin
               state_nxt_s = STREAM;
            end else begin
               state_nxt_s = LOAD_W;
            end
         end
         STREAM: begin
            pxl_rd_en_s = mem_bus.mem_grant;
            p_issue_s   = mem_bus.mem_grant;
            if (mem_bus.mem_grant && (p_r == P_LAST)) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = STREAM;
            end
         end
         DRAIN: begin
            res_hit_s = res_valid;
            if (res_valid && (res_cnt_r == RC_LAST)) begin
               res_last_s = 1'b1;
               if (oc_r == OC_LAST) begin
                  state_nxt_s = DONE;
               end else begin
                  ch_next_s   = 1'b1;
                  state_nxt_s = LOAD_W;
               end
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         DONE: begin
            layer_end_s = 1'b1;
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Loop counters, channel index and latched layer configuration
   always_ff @(posedge clk) begin
      if (reset) begin
         ic_r      <= {IC_W{1'b0}};
         p_r       <= {P_ADDR_W{1'b0}};
         res_cnt_r <= {RC_W{1'b0}};
         w_base_r  <= {W_ADDR_W{1'b0}};
         oc_r      <= 16'd0;
         busy_r    <= 1'b0;
         stride2_r <= 1'b0;
      end else begin
         if (start_acc_s) begin
            ic_r      <= {IC_W{1'b0}};
            p_r       <= {P_ADDR_W{1'b0}};
            res_cnt_r <= {RC_W{1'b0}};
            w_base_r  <= {W_ADDR_W{1'b0}};
            oc_r      <= 16'd0;
            busy_r    <= 1'b1;
            stride2_r <= stride2_cfg;
         end
         if (w_issue_s) begin
            ic_r <= (ic_r == IC_LAST) ? {IC_W{1'b0}} : (ic_r + IC_W'(1));
         end
         if (p_issue_s) begin
            p_r <= (p_r == P_LAST) ? {P_ADDR_W{1'b0}} : (p_r + P_ADDR_W'(1));
         end
         // The result counter only clears when DRAIN is left.
         if (res_hit_s) begin
            res_cnt_r <= res_last_s ? {RC_W{1'b0}} : (res_cnt_r + RC_W'(1));
         end
         if (ch_next_s) begin
            oc_r     <= oc_r + 16'd1;
            w_base_r <= w_base_r + W_STRIDE;
         end
         if (layer_end_s) begin
            busy_r <= 1'b0;
         end
      end
   end

   // Forward strobes lag the read strobes by one cycle; data words hold
   // their last forwarded value between strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         vw_r     <= 1'b0;
         vp_r     <= 1'b0;
         w_hold_r <= {DATA_WIDTH{1'b0}};
         p_hold_r <= {DATA_WIDTH{1'b0}};
      end else begin
         vw_r <= wgt_rd_en_s;
         vp_r <= pxl_rd_en_s;
         if (vw_r) begin
            w_hold_r <= mem_bus.wgt_rd_data;
         end
         if (vp_r) begin
            p_hold_r <= mem_bus.pxl_rd_data;
         end
      end
   end

   // Memory data arrives in the strobe cycle, so it is passed straight through.
   assign weight_in           = vw_r ? mem_bus.wgt_rd_data : w_hold_r;
   assign pxl_in              = vp_r ? mem_bus.pxl_rd_data : p_hold_r;
   assign valid_weight_in     = vw_r;
   assign valid_in            = vp_r;

   assign mem_bus.wgt_rd_en   = wgt_rd_en_s;
   assign mem_bus.wgt_rd_addr = w_base_r + W_ADDR_W'(ic_r);
   assign mem_bus.pxl_rd_en   = pxl_rd_en_s;
   assign mem_bus.pxl_rd_addr = p_r;

   assign stride2             = stride2_r;
   assign oc_idx              = oc_r;
   assign busy                = busy_r;
   assign done                = (state_r == DONE);

endmodule

// File: tb/tb_conv_1x1_sched.sv
// ---------------------------------------------------------------------------
// tb_conv_1x1_sched
// Directed bench for conv_1x1_sched with a small layer (4 in, 2 out, 3 px).
// Stimulus pushes expected read addresses and forwarded data into queues;
// a negedge monitor pops and compares whenever the DUT strobes.
// ---------------------------------------------------------------------------
module tb_conv_1x1_sched;
   localparam int DW = 32;
   localparam int CI = 4;
   localparam int CO = 2;
   localparam int IS = 3;
   localparam int WA = 20;
   localparam int PA = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          stride2_cfg;
   logic          res_valid;
   logic          valid_weight_in;
   logic [DW-1:0] weight_in;
   logic          valid_in;
   logic [DW-1:0] pxl_in;
   logic          stride2;
   logic [15:0]   oc_idx;
   logic          busy;
   logic          done;

   conv_1x1_sched_if #(.DATA_WIDTH(DW), .W_ADDR_W(WA), .P_ADDR_W(PA)) mem_if ();

   conv_1x1_sched #(
      .DATA_WIDTH(DW), .CHANNEL_NUM_IN(CI), .CHANNEL_NUM_OUT(CO),
      .IMAGE_SIZE(IS), .W_ADDR_W(WA), .P_ADDR_W(PA)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stride2_cfg(stride2_cfg),
      .mem_bus(mem_if), .valid_weight_in(valid_weight_in), .weight_in(weight_in),
      .valid_in(valid_in), .pxl_in(pxl_in), .stride2(stride2),
      .res_valid(res_valid), .oc_idx(oc_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int vw_cnt = 0;
   int vi_cnt = 0;
   bit grant_toggle = 1'b0;

   logic [WA-1:0] exp_wa[$];
   logic [PA-1:0] exp_pa[$];
   logic [DW-1:0] exp_wd[$];
   logic [DW-1:0] exp_pd[$];
   logic [DW-1:0] last_wd = '0;
   logic [DW-1:0] last_pd = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory model: data = address + 100, one cycle after the strobe.
   always @(posedge clk) begin
      if (mem_if.wgt_rd_en === 1'b1) mem_if.wgt_rd_data <= DW'(mem_if.wgt_rd_addr) + 32'd100;
      if (mem_if.pxl_rd_en === 1'b1) mem_if.pxl_rd_data <= DW'(mem_if.pxl_rd_addr) + 32'd100;
   end

   // Grant source, changed away from both clock edges.
   always @(posedge clk) begin
      #2;
      if (grant_toggle) mem_if.mem_grant = ~mem_if.mem_grant;
      else              mem_if.mem_grant = 1'b1;
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (mem_if.wgt_rd_en && mem_if.pxl_rd_en)
            chk("rd_exclusive", {mem_if.wgt_rd_en, mem_if.pxl_rd_en}, 64'd2);
         if (mem_if.mem_grant === 1'b0)
            chk("no_rd_without_grant", {mem_if.wgt_rd_en, mem_if.pxl_rd_en}, 64'd0);
         if (mem_if.wgt_rd_en) begin
            if (exp_wa.size() == 0) chk("wgt_rd_unexpected", mem_if.wgt_rd_en, 64'd0);
            else chk("wgt_rd_addr", mem_if.wgt_rd_addr, exp_wa.pop_front());
         end
         if (mem_if.pxl_rd_en) begin
            if (exp_pa.size() == 0) chk("pxl_rd_unexpected", mem_if.pxl_rd_en, 64'd0);
            else chk("pxl_rd_addr", mem_if.pxl_rd_addr, exp_pa.pop_front());
         end
         if (valid_weight_in) begin
            vw_cnt++;
            if (exp_wd.size() == 0) chk("valid_weight_unexpected", valid_weight_in, 64'd0);
            else begin
               last_wd = exp_wd.pop_front();
               chk("weight_in", weight_in, last_wd);
            end
         end else begin
            chk("weight_in_hold", weight_in, last_wd);
         end
         if (valid_in) begin
            vi_cnt++;
            if (exp_pd.size() == 0) chk("valid_in_unexpected", valid_in, 64'd0);
            else begin
               last_pd = exp_pd.pop_front();
               chk("pxl_in", pxl_in, last_pd);
            end
         end else begin
            chk("pxl_in_hold", pxl_in, last_pd);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid_weight_in"}, valid_weight_in, 64'd0);
      chk({tag, "_weight_in"}, weight_in, 64'd0);
      chk({tag, "_valid_in"}, valid_in, 64'd0);
      chk({tag, "_pxl_in"}, pxl_in, 64'd0);
      chk({tag, "_stride2"}, stride2, 64'd0);
      chk({tag, "_oc_idx"}, oc_idx, 64'd0);
      chk({tag, "_busy"}, busy, 64'd0);
      chk({tag, "_done"}, done, 64'd0);
      chk({tag, "_wgt_rd_en"}, mem_if.wgt_rd_en, 64'd0);
      chk({tag, "_pxl_rd_en"}, mem_if.pxl_rd_en, 64'd0);
      chk({tag, "_wgt_rd_addr"}, mem_if.wgt_rd_addr, 64'd0);
      chk({tag, "_pxl_rd_addr"}, mem_if.pxl_rd_addr, 64'd0);
   endtask

   task automatic push_layer();
      for (int oc = 0; oc < CO; oc++) begin
         for (int ic = 0; ic < CI; ic++) begin
            exp_wa.push_back(WA'(oc * CI + ic));
            exp_wd.push_back(DW'(oc * CI + ic + 100));
         end
         for (int p = 0; p < IS * CI; p++) begin
            exp_pa.push_back(PA'(p));
            exp_pd.push_back(DW'(p + 100));
         end
      end
   endtask

   task automatic wait_vi(input int target);
      int n = 0;
      while (vi_cnt < target && n < 400) begin
         step();
         n++;
      end
      chk("stream_count", vi_cnt, target);
   endtask

   // One full layer; 'extra' injects a stray res_valid in LOAD_W and a
   // stray start in DRAIN.
   task automatic run_layer(input logic s2, input bit extra);
      int base = vi_cnt;
      push_layer();
      stride2_cfg = s2;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("busy_after_start", busy, 64'd1);
      chk("stride2_latched", stride2, s2);
      stride2_cfg = ~s2;
      for (int oc = 0; oc < CO; oc++) begin
         chk("oc_idx", oc_idx, oc);
         if (extra) begin
            res_valid = 1'b1;
            step();
            res_valid = 1'b0;
         end
         wait_vi(base + (oc + 1) * IS * CI);
         if (extra) begin
            start = 1'b1;
            step();
            start = 1'b0;
            chk("busy_stray_start", busy, 64'd1);
            chk("oc_idx_stray_start", oc_idx, oc);
         end
         chk("stride2_hold", stride2, s2);
         for (int k = 0; k < IS; k++) begin
            res_valid = 1'b1;
            step();
            res_valid = 1'b0;
            chk("done_timing", done, (oc == CO - 1 && k == IS - 1) ? 64'd1 : 64'd0);
            chk("busy_in_layer", busy, 64'd1);
         end
      end
      step();
      chk("done_one_cycle", done, 64'd0);
      chk("busy_cleared", busy, 64'd0);
      chk("stride2_after_layer", stride2, s2);
      chk("wgt_queue_empty", exp_wa.size(), 64'd0);
      chk("pxl_queue_empty", exp_pa.size(), 64'd0);
   endtask

   initial begin
      bit found;
      reset = 1'b1;
      start = 1'b0;
      stride2_cfg = 1'b0;
      res_valid = 1'b0;
      step();
      step();
      check_all_zero("reset");
      reset = 1'b0;
      step();

      // Scenarios 1 and 2: basic layer, data forwarding and strobe counts
      run_layer(1'b0, 1'b0);
      chk("valid_weight_in_count", vw_cnt, 64'd8);
      chk("valid_in_count", vi_cnt, 64'd24);

      // Scenario 3: grant toggling
      grant_toggle = 1'b1;
      run_layer(1'b0, 1'b0);
      grant_toggle = 1'b0;
      step();
      step();

      // Scenario 4: stride2 latched at start, config changed while busy
      run_layer(1'b1, 1'b0);
      step();
      chk("stride2_idle_hold", stride2, 64'd1);

      // Scenario 5: reset during STREAM at pixel address 5
      push_layer();
      stride2_cfg = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 200 && !found; n++) begin
         step();
         if (mem_if.pxl_rd_en && mem_if.pxl_rd_addr == PA'(5)) found = 1'b1;
      end
      chk("reach_pxl_addr_5", found, 64'd1);
      reset = 1'b1;
      exp_wa.delete();
      exp_pa.delete();
      exp_wd.delete();
      exp_pd.delete();
      step();
      check_all_zero("abort");
      last_wd = '0;
      last_pd = '0;
      reset = 1'b0;
      step();
      chk("no_done_after_abort", done, 64'd0);
      run_layer(1'b0, 1'b0);

      // Scenario 6: stray start in DRAIN and stray res_valid in LOAD_W
      run_layer(1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/conv_1x1_sched.md
Name: conv_1x1_sched

Overview:
- Sequencer for the 1x1 convolution chain (loop-data reorder -> 1x1 conv core -> channel adder).
- Runs one layer per `start` pulse, processing one output channel at a time:
  - fetches that channel's CHANNEL_NUM_IN weights from weight memory into the conv core;
  - streams the full input feature map (IMAGE_SIZE*CHANNEL_NUM_IN words) from pixel memory;
  - waits until the adder has returned IMAGE_SIZE results.
- Sits between the layer-level controller/memories and the conv chain inputs.

Parameters:
- DATA_WIDTH, 32, pixel/weight word width.
- CHANNEL_NUM_IN, 2048, input channels.
- CHANNEL_NUM_OUT, 256, output channels.
- IMAGE_SIZE, 256, pixels per channel (width*height).
- W_ADDR_W, 20, weight address width; must be >= clog2(CHANNEL_NUM_IN*CHANNEL_NUM_OUT).
- P_ADDR_W, 20, pixel address width; must be >= clog2(IMAGE_SIZE*CHANNEL_NUM_IN).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle layer start; ignored unless idle.
- stride2_cfg  in  1  stride-2 mode; sampled on accepted start.
- mem_grant  in  1  memory port available this cycle.
- wgt_rd_en  out  1  weight read strobe.
- wgt_rd_addr  out  W_ADDR_W  weight read address.
- wgt_rd_data  in  DATA_WIDTH  weight data, valid exactly 1 cycle after wgt_rd_en.
- pxl_rd_en  out  1  pixel read strobe.
- pxl_rd_addr  out  P_ADDR_W  pixel read address.
- pxl_rd_data  in  DATA_WIDTH  pixel data, valid exactly 1 cycle after pxl_rd_en.
- valid_weight_in  out  1  to conv core.
- weight_in  out  DATA_WIDTH  to conv core.
- valid_in  out  1  to loop-data block.
- pxl_in  out  DATA_WIDTH  to loop-data block.
- stride2  out  1  to conv core; latched config.
- res_valid  in  1  valid_out of channel adder.
- oc_idx  out  16  current output channel.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at layer end.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Reset mid-operation aborts the layer and returns to IDLE the next cycle, with no done pulse. Data returning for a read issued before reset is discarded.
- States:
  - IDLE -> LOAD_W on start; stride2 <= stride2_cfg, oc_idx <= 0, busy <= 1.
  - LOAD_W: wgt_rd_en = mem_grant. Each granted cycle issues wgt_rd_addr = oc_idx*CHANNEL_NUM_IN + ic, then increments ic. After issuing ic = CHANNEL_NUM_IN-1 -> STREAM, with ic cleared.
  - STREAM: pxl_rd_en = mem_grant. Each granted cycle issues pxl_rd_addr = p, then increments p (0..IMAGE_SIZE*CHANNEL_NUM_IN-1, linear). After the last read -> DRAIN, with p cleared.
  - DRAIN: counts res_valid pulses. On the IMAGE_SIZE-th pulse:
    - if oc_idx == CHANNEL_NUM_OUT-1 -> DONE;
    - else oc_idx++ and -> LOAD_W.
  - DONE: done = 1 for one cycle, busy <= 0 -> IDLE.
- Memory access:
  - No read is issued while mem_grant = 0; the address holds.
  - wgt_rd_en and pxl_rd_en are never high together.
- Forwarding to the conv chain:
  - valid_weight_in is wgt_rd_en delayed 1 cycle (registered); weight_in = wgt_rd_data in that cycle.
  - valid_in is pxl_rd_en delayed 1 cycle (registered); pxl_in = pxl_rd_data in that cycle.
  - Data outputs are held at the last value when their valid is 0.
- Transition timing:
  - The last weight is forwarded in the same cycle as the first possible pixel read, so the first valid_in is at least 1 cycle after the last valid_weight_in.
  - LOAD_W for the next channel starts the cycle after the final res_valid.
- res_valid outside DRAIN is an error: it is ignored and does not count.
- start while busy is ignored.
- The result counter is wide enough for IMAGE_SIZE; it wraps only on state exit.

Test Plan:
1. CHANNEL_NUM_IN=4, CHANNEL_NUM_OUT=2, IMAGE_SIZE=3, mem_grant=1, start pulse:
   - weight addrs 0,1,2,3, then pixel addrs 0..11;
   - 3 res_valid -> weight addrs 4..7, pixel addrs 0..11;
   - 3 res_valid -> done pulse 1 cycle later; busy low after it.
2. Read data = address+100 -> weight_in / pxl_in equal 100.. one cycle after each strobe; valid_weight_in count = 8, valid_in count = 24.
3. mem_grant toggling 1,0,1,0 during LOAD_W -> addresses advance only on granted cycles; no duplicate or skipped addresses.
4. stride2_cfg=1 at start, then changed to 0 while busy -> stride2 stays 1 until the next start.
5. Reset asserted in STREAM at pixel addr 5 -> next cycle all outputs 0 and busy 0; a new start restarts at weight addr 0.
6. Extra start during DRAIN and res_valid while in LOAD_W -> both ignored; sequence and done timing identical to scenario 1.
